// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    // Even parity bit: XOR of all data bits.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Flops preset to 1 so an idle UART line does not look like a start bit out of reset.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset (presets all stages to 1)
//   d_i    - asynchronous input
//   q_o    - synchronized output
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits MSB-first, even parity, 1 stop bit.
// Oversamples the synchronized line, rebuilds the byte and reports parity/stop errors.
// Optional macro UART_RX_HOLD_EN adds a valid/ready hold with overrun detection.
// Ports:
//   rx_clk          - receiver clock, OVERSAMPLE x bit rate
//   rx_en           - asynchronous active-low reset
//   rx_i            - serial input, asynchronous to rx_clk
//   rx_o_data       - received byte
//   rx_o_data_valid - data/error flags valid (strobe, or held until ready with UART_RX_HOLD_EN)
//   rx_o_parity_err - parity mismatch on the last frame
//   rx_o_frame_err  - stop bit sampled low on the last frame
//   rx_o_busy       - frame in progress
//   rx_i_ready      - consumer ready (UART_RX_HOLD_EN only)
//   rx_o_overrun    - a held frame was overwritten, sticky (UART_RX_HOLD_EN only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      rx_clk,
    input  logic                      rx_en,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_o_data,
    output logic                      rx_o_data_valid,
    output logic                      rx_o_parity_err,
    output logic                      rx_o_frame_err,
    output logic                      rx_o_busy
`ifdef UART_RX_HOLD_EN
    ,
    input  logic                      rx_i_ready,
    output logic                      rx_o_overrun
`endif
);

    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = 3;
    localparam logic [TCNT_W-1:0] TICK_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(UART_DATA_BITS - 1);

    logic rxs;

    rx_state_t                 state_q,  state_d;
    logic [TCNT_W-1:0]         tcnt_q,   tcnt_d;
    logic [BCNT_W-1:0]         bcnt_q,   bcnt_d;
    logic [UART_DATA_BITS-1:0] shreg_q,  shreg_d;
    logic                      perr_q,   perr_d;
    logic [UART_DATA_BITS-1:0] data_q,   data_d;
    logic                      valid_q,  valid_d;
    logic                      parerr_q, parerr_d;
    logic                      frmerr_q, frmerr_d;
    logic                      busy_q,   busy_d;
    logic                      overrun_q, overrun_d;
    logic                      done_c;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (rx_clk),
        .rst_ni (rx_en),
        .d_i    (rx_i),
        .q_o    (rxs)
    );

    // State and datapath registers.
    always_ff @(posedge rx_clk or negedge rx_en) begin
        if (!rx_en) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            parerr_q  <= 1'b0;
            frmerr_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            parerr_q  <= parerr_d;
            frmerr_q  <= frmerr_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        data_d    = data_q;
        parerr_d  = parerr_q;
        frmerr_d  = frmerr_q;
        overrun_d = overrun_q;
        done_c    = 1'b0;
`ifdef UART_RX_HOLD_EN
        valid_d   = valid_q & ~rx_i_ready;
`else
        valid_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (rxs != UART_IDLE_LEVEL) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (tcnt_q == TICK_MID) begin
                    if (rxs == UART_IDLE_LEVEL) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            DATA: begin
                if (tcnt_q == TICK_LAST) begin
                    shreg_d = {shreg_q[UART_DATA_BITS-2:0], rxs};
                    tcnt_d  = '0;
                    if (bcnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            PARITY: begin
                if (tcnt_q == TICK_LAST) begin
                    perr_d  = rxs ^ even_parity(shreg_q);
                    state_d = STOP;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start edge in its second half is caught.
                if (tcnt_q == TICK_LAST) begin
                    done_c  = 1'b1;
                    tcnt_d  = '0;
                    state_d = (rxs == UART_IDLE_LEVEL) ? IDLE : BREAK_WAIT;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            BREAK_WAIT: begin
                if (rxs == UART_IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_c) begin
            data_d   = shreg_q;
            parerr_d = perr_q;
            frmerr_d = ~rxs;
`ifdef UART_RX_HOLD_EN
            // New frame overwrites a still-unaccepted one.
            if (valid_q && !rx_i_ready) begin
                overrun_d = 1'b1;
            end
`endif
            valid_d  = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign rx_o_data       = data_q;
    assign rx_o_data_valid = valid_q;
    assign rx_o_parity_err = parerr_q;
    assign rx_o_frame_err  = frmerr_q;
    assign rx_o_busy       = busy_q;
`ifdef UART_RX_HOLD_EN
    assign rx_o_overrun    = overrun_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames,
// compared against a frame-level reference model (expected byte and error flags
// derived from the bits that were put on the line).
module tb_uart_rx;

    localparam int unsigned OS      = 16;
    localparam int unsigned SS      = 2;
    localparam int unsigned CLK_P   = 10;
    localparam int unsigned BIT     = OS * CLK_P;
    localparam int unsigned FRAME_C = 11 * OS;

    logic       rx_clk;
    logic       rx_en;
    logic       rx_i;
    logic [7:0] rx_o_data;
    logic       rx_o_data_valid;
    logic       rx_o_parity_err;
    logic       rx_o_frame_err;
    logic       rx_o_busy;
`ifdef UART_RX_HOLD_EN
    logic       rx_i_ready;
    logic       rx_o_overrun;
`endif

    uart_rx #(
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (SS)
    ) dut (
        .rx_clk          (rx_clk),
        .rx_en           (rx_en),
        .rx_i            (rx_i),
        .rx_o_data       (rx_o_data),
        .rx_o_data_valid (rx_o_data_valid),
        .rx_o_parity_err (rx_o_parity_err),
        .rx_o_frame_err  (rx_o_frame_err),
        .rx_o_busy       (rx_o_busy)
`ifdef UART_RX_HOLD_EN
        ,
        .rx_i_ready      (rx_i_ready),
        .rx_o_overrun    (rx_o_overrun)
`endif
    );

    initial rx_clk = 1'b0;
    always #(CLK_P / 2) rx_clk = ~rx_clk;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned t;
    } frame_t;

    frame_t got_q[$];
    frame_t exp_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned run    = 0;
    int unsigned max_run = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge rx_clk) cyc <= cyc + 1;

    // Monitor: record each valid assertion and the longest high run.
    always @(negedge rx_clk) begin
        if (rx_o_data_valid) begin
            run = run + 1;
            if (run > max_run) max_run = run;
            if (run == 1) got_q.push_back('{rx_o_data, rx_o_parity_err, rx_o_frame_err, cyc});
        end else begin
            run = 0;
        end
    end

    task automatic align();
        @(posedge rx_clk);
        #(1 + $urandom_range(0, 7));
    endtask

    // Drive one frame; bad_par flips the parity bit, bad_stop sends a 0 stop bit
    // followed by extra_low further low bit periods before releasing the line.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int unsigned extra_low);
        rx_i = 1'b0;
        #(BIT);
        for (int i = 7; i >= 0; i--) begin
            rx_i = d[i];
            #(BIT);
        end
        rx_i = (^d) ^ bad_par;
        #(BIT);
        rx_i = ~bad_stop;
        #(BIT);
        exp_q.push_back('{d, bad_par, bad_stop, 0});
        if (bad_stop) begin
            #(extra_low * BIT);
            chk_eq("busy_in_break", 32'(rx_o_busy), 32'd1);
            rx_i = 1'b1;
            #((SS + 3) * CLK_P);
            chk_eq("busy_after_break", 32'(rx_o_busy), 32'd0);
        end
    endtask

    task automatic check_frames(input string tag);
        frame_t g;
        frame_t e;
        chk_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk_eq({tag, "_data"}, 32'(g.d), 32'(e.d));
            chk_eq({tag, "_perr"}, 32'(g.pe), 32'(e.pe));
            chk_eq({tag, "_ferr"}, 32'(g.fe), 32'(e.fe));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rx_en = 1'b0;
        rx_i  = 1'b1;
`ifdef UART_RX_HOLD_EN
        rx_i_ready = 1'b1;
`endif
        #(3 * CLK_P + 2);
        chk_eq("rst_valid", 32'(rx_o_data_valid), 32'd0);
        chk_eq("rst_data",  32'(rx_o_data), 32'd0);
        chk_eq("rst_perr",  32'(rx_o_parity_err), 32'd0);
        chk_eq("rst_ferr",  32'(rx_o_frame_err), 32'd0);
        chk_eq("rst_busy",  32'(rx_o_busy), 32'd0);
        align();
        rx_en = 1'b1;
        #(4 * BIT);
        chk_eq("idle_busy", 32'(rx_o_busy), 32'd0);

        // Clean frame.
        align();
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        #(2 * BIT);
        check_frames("a5");
        chk_eq("a5_busy_after", 32'(rx_o_busy), 32'd0);

        // Parity error.
        align();
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        #(2 * BIT);
        check_frames("3c");

        // Framing error with extended break.
        align();
        send_frame(8'h81, 1'b0, 1'b1, 3);
        #(2 * BIT);
        check_frames("81");
        chk_eq("81_ferr_hold", 32'(rx_o_frame_err), 32'd1);

        // Short glitch must not start a frame.
        align();
        rx_i = 1'b0;
        #(4 * CLK_P);
        rx_i = 1'b1;
        #((OS / 2 + SS + 2) * CLK_P);
        chk_eq("glitch_busy", 32'(rx_o_busy), 32'd0);
        #(2 * BIT);
        chk_eq("glitch_novalid", 32'(got_q.size()), 32'd0);

        // Back-to-back frames with no idle gap.
        align();
        send_frame(8'h00, 1'b0, 1'b0, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 0);
        #(2 * BIT);
        chk_eq("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) chk_eq("b2b_spacing", got_q[1].t - got_q[0].t, 32'(FRAME_C));
        check_frames("b2b");

        // Reset in the middle of data bit 4 discards the frame.
        align();
        rx_i = 1'b0;
        #(BIT);
        for (int i = 7; i >= 4; i--) begin
            rx_i = 8'h55 >> i;
            #(BIT);
        end
        rx_i = 1'b0;
        #(BIT / 2);
        rx_en = 1'b0;
        rx_i  = 1'b1;
        #(3 * CLK_P);
        rx_en = 1'b1;
        #(3 * BIT);
        chk_eq("rstmid_novalid", 32'(got_q.size()), 32'd0);
        chk_eq("rstmid_busy", 32'(rx_o_busy), 32'd0);
        align();
        send_frame(8'h12, 1'b0, 1'b0, 0);
        #(2 * BIT);
        check_frames("12");

        // Randomized frames with random errors and gaps.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            bit bp;
            bit bs;
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            send_frame(d, bp, bs, $urandom_range(0, 2));
            #($urandom_range(bs ? BIT / 4 : 0, 2 * BIT));
        end
        #(2 * BIT);
        check_frames("rand");

        chk_eq("valid_width", max_run, 32'd1);

`ifdef UART_RX_HOLD_EN
        // Two frames without acceptance: second overwrites, overrun sticks.
        rx_i_ready = 1'b0;
        align();
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        send_frame(8'hC3, 1'b0, 1'b0, 0);
        #(2 * BIT);
        chk_eq("hold_valid", 32'(rx_o_data_valid), 32'd1);
        chk_eq("hold_overrun", 32'(rx_o_overrun), 32'd1);
        chk_eq("hold_data", 32'(rx_o_data), 32'hC3);
        @(negedge rx_clk);
        rx_i_ready = 1'b1;
        @(negedge rx_clk);
        @(negedge rx_clk);
        chk_eq("hold_released", 32'(rx_o_data_valid), 32'd0);
        chk_eq("hold_overrun_sticky", 32'(rx_o_overrun), 32'd1);
        got_q.delete();
        exp_q.delete();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the UART transmitter's serial output.
- Frame format matches the transmitter: 1 start bit (0), 8 data bits MSB-first, 1 even-parity bit (parity = XOR of the data bits), 1 stop bit (1). Idle line is high.
- Oversamples the line, reassembles the byte, checks parity and stop, and presents the byte with a one-cycle valid strobe to the downstream consumer.

Parameters:
- OVERSAMPLE, 16, rx_clk cycles per bit period. Must be even and >= 4.
- SYNC_STAGES, 2, flops in the input synchronizer. Must be >= 2.

Ports:
- rx_clk  input  1  receiver clock, OVERSAMPLE x bit rate
- rx_en  input  1  asynchronous active-low reset
- rx_i  input  1  serial data input, asynchronous to rx_clk
- rx_o_data  output  8  received byte
- rx_o_data_valid  output  1  one-cycle strobe, rx_o_data and error flags valid
- rx_o_parity_err  output  1  parity mismatch on the last frame
- rx_o_frame_err  output  1  stop bit sampled 0 on the last frame
- rx_o_busy  output  1  high while a frame is in progress
- rx_i_ready  input  1  consumer ready; present only with UART_RX_HOLD_EN
- rx_o_overrun  output  1  frame lost; present only with UART_RX_HOLD_EN

Behaviour:
- Reset (rx_en=0, asynchronous): all outputs 0, synchronizer flops 1, state IDLE, counters 0.
- rx_i passes through SYNC_STAGES flops; all logic below uses the synchronized value (rxs).
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- Tick counter: tcnt, width clog2(OVERSAMPLE). Bit counter: bcnt, 3 bits.
- IDLE: a low rxs moves the FSM to START with tcnt=0. rx_o_busy=0 only in IDLE.
- START: at tcnt==OVERSAMPLE/2-1 (mid-bit), sample rxs.
  - rxs=1: false start, return to IDLE with no output.
  - rxs=0: go to DATA with tcnt=0, bcnt=0.
- DATA: sample at tcnt==OVERSAMPLE-1, then tcnt wraps to 0.
  - Shift register: shreg <= {shreg[6:0], rxs}, so the first-received bit ends in bit 7.
  - After the sample with bcnt==7, go to PARITY.
- PARITY: sample at tcnt==OVERSAMPLE-1. perr = rxs XOR (^shreg). Go to STOP.
- STOP: sample at tcnt==OVERSAMPLE-1 (mid stop bit). On the next edge:
  - rx_o_data <= shreg, rx_o_parity_err <= perr, rx_o_frame_err <= ~rxs.
  - rx_o_data_valid pulses high for exactly 1 cycle, including frames with errors.
  - rxs=1: go to IDLE immediately, so a start edge in the second half of the stop bit is accepted.
  - rxs=0: go to BREAK_WAIT.
- BREAK_WAIT: stay until rxs==1, then go to IDLE. Busy stays high.
- rx_o_data and the error flags hold until the next frame completes.
- Latency: valid rises SYNC_STAGES+1 cycles after the mid-stop point of rx_i.
- Reset mid-frame: the partial frame is discarded, no valid is produced, and the FSM restarts in IDLE.

Optional Feature:
- Macro: UART_RX_HOLD_EN.
- Defined:
  - rx_i_ready and rx_o_overrun ports exist.
  - rx_o_data_valid stays high from frame completion until the cycle rx_i_ready=1 (valid&&ready handshake).
  - If a new frame completes while valid is still high and unaccepted: new data overwrites the held data, rx_o_overrun is set and stays set until reset, and valid remains high.
- Undefined: valid is a single-cycle strobe, the ports are absent, and there is no back-pressure.

Decomposition:
- Package uart_pkg:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT}.
  - Constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
  - Function even_parity(byte).
  - Shared with the transmitter.
- Sub-module uart_sync: parameterized SYNC_STAGES synchronizer with asynchronous active-low reset and preset value 1.

Test Plan:
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1; parity 0; stop 1), OVERSAMPLE=16 -> one valid pulse, rx_o_data=0xA5, both error flags 0, busy low afterwards.
- Frame 0x3C sent with parity bit 1 -> valid pulse, rx_o_data=0x3C, rx_o_parity_err=1, rx_o_frame_err=0.
- Frame 0x81 with stop bit 0, line held low for 3 more bit periods -> valid, rx_o_frame_err=1, busy high until the line returns high, then IDLE.
- 4-cycle low glitch on an idle line -> no valid, FSM back in IDLE within OVERSAMPLE/2+SYNC_STAGES cycles.
- Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses 11 bit periods apart, data correct, no errors.
- rx_en pulsed low during data bit 4 of 0x55, then clean frame 0x12 -> no valid for 0x55, valid with 0x12. With UART_RX_HOLD_EN and rx_i_ready=0 for two frames -> rx_o_overrun=1, second byte held.
